// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and word constants.
package instruction_memory_loader_pkg;

  // Loader FSM: wait for a program, stream it in, flag completion, let the core run.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2,
    StRun  = 2'd3
  } state_e;

  // sll $0,$0,0 -- returned for any fetch that must not see RAM.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int unsigned INSTR_BYTES_PER_WORD = 4;

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Fetch port and host byte link of the instruction memory loader.
interface instruction_memory_loader_if #(
  parameter int unsigned ADDR_W = 8
);

  logic [31:0]     pc_register;
  logic [31:0]     IF_instruction;
  logic            load_start;
  logic [ADDR_W:0] load_length;
  logic [7:0]      load_byte;
  logic            load_valid;
  logic            load_ready;
  logic            core_hold;
  logic            load_done;
  logic            load_error;

  // Core fetch stage plus host loader side.
  modport master (
    output pc_register,
    output load_start,
    output load_length,
    output load_byte,
    output load_valid,
    input  IF_instruction,
    input  load_ready,
    input  core_hold,
    input  load_done,
    input  load_error
  );

  // The loader itself.
  modport slave (
    input  pc_register,
    input  load_start,
    input  load_length,
    input  load_byte,
    input  load_valid,
    output IF_instruction,
    output load_ready,
    output core_hold,
    output load_done,
    output load_error
  );

endinterface

// File: rtl/instruction_memory_loader_ram.sv
// Instruction RAM: synchronous write, asynchronous read, no reset on contents.
module instruction_memory_loader_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Word write from the byte assembler.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction-side responder and program loader: assembles host bytes into words, writes them
// to instruction RAM while holding the core in reset, then serves fetches once running.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  instruction_memory_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [ADDR_W:0] WordOne  = (ADDR_W + 1)'(1);
  localparam logic [1:0]      LastByte = 2'(INSTR_BYTES_PER_WORD - 1);

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [ADDR_W:0] word_cnt_q, word_cnt_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            err_q, err_d;

  logic            start_legal;
  logic            accept;
  logic            word_wr;
  logic            last_word;
  logic            load_ready;
  logic            core_hold;
  logic            load_done;
  logic            fetch_ok;
  logic [31:0]     ram_rdata;

  assign start_legal = (bus.load_length != '0) && (bus.load_length <= DepthLen);
  assign accept      = (state_q == StLoad) && bus.load_valid;
  assign word_wr     = accept && (byte_cnt_q == LastByte);
  // word_cnt_q < len_q <= DEPTH_WORDS, so the increment never overflows ADDR_W+1 bits.
  assign last_word   = word_wr && ((word_cnt_q + WordOne) == len_q);

  // Next-state, byte assembly and handshake outputs.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    load_ready = 1'b0;
    core_hold  = 1'b1;
    load_done  = 1'b0;

    case (state_q)
      StIdle, StRun: begin
        core_hold = (state_q == StIdle);
        if (bus.load_start) begin
          if (start_legal) begin
            state_d    = StLoad;
            len_d      = bus.load_length;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // load_start is deliberately ignored here so a stray pulse cannot restart the load.
        load_ready = 1'b1;
        if (accept) begin
          shift_d    = {shift_q[15:0], bus.load_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (word_wr) begin
            word_cnt_d = word_cnt_q + WordOne;
          end
          if (last_word) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        load_done = 1'b1;
        state_d   = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and counters; reset aborts any load in flight and drops the partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
    end
  end

  instruction_memory_loader_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (word_wr),
    .waddr_i (word_cnt_q[ADDR_W-1:0]),
    .wdata_i ({shift_q, bus.load_byte}),
    .raddr_i (bus.pc_register[ADDR_W+1:2]),
    .rdata_o (ram_rdata)
  );

  // Reads are masked outside RUN, so a fetch never races a loader write.
  assign fetch_ok = (state_q == StRun) && (bus.pc_register[1:0] == 2'b00) &&
                    (bus.pc_register[31:ADDR_W+2] == '0);

  assign bus.IF_instruction = fetch_ok ? ram_rdata : NOP_WORD;
  assign bus.load_ready     = load_ready;
  assign bus.core_hold      = core_hold;
  assign bus.load_done      = load_done;
  assign bus.load_error     = err_q;

endmodule
